// File: rtl/dbus_arbiter.sv
// Two-port data-bus arbiter: p0 (uncached access) has priority over p1 (write-buffer drain), bounded by a starvation limit.
// Latency: request seen in IDLE at cycle N is presented downstream at N+1; ok pulses combinationally on the accepted data_ok.
// Backpressure: one transaction in flight; a port is stalled until the FSM returns to IDLE and grants it.
module dbus_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int DATA_W       = 64
) (
  input  logic                clk,
  input  logic                reset,

  input  logic                p0_valid,
  input  logic [31:0]         p0_addr,
  input  logic [2:0]          p0_size,
  input  logic [DATA_W/8-1:0] p0_strobe,
  input  logic [DATA_W-1:0]   p0_data,

  input  logic                p1_valid,
  input  logic [31:0]         p1_addr,
  input  logic [2:0]          p1_size,
  input  logic [DATA_W/8-1:0] p1_strobe,
  input  logic [DATA_W-1:0]   p1_data,

  output logic                p0_ok,
  output logic                p1_ok,
  output logic [DATA_W-1:0]   rdata,

  output logic                dbus_valid,
  output logic [31:0]         dbus_addr,
  output logic [2:0]          dbus_size,
  output logic [DATA_W/8-1:0] dbus_strobe,
  output logic [DATA_W-1:0]   dbus_data,

  input  logic                dbus_addr_ok,
  input  logic                dbus_data_ok,
  input  logic [DATA_W-1:0]   dbus_rdata,

  input  logic                fence,
  output logic                busy
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CW-1:0]         r_starve_cnt;
  logic                  r_sel_p1;
  logic [31:0]           r_addr;
  logic [2:0]            r_size;
  logic [DATA_W/8-1:0]   r_strobe;
  logic [DATA_W-1:0]     r_data;

  logic                  w_starved;
  logic                  w_grant_p0;
  logic                  w_grant_p1;
  logic                  w_grant;
  logic                  w_done;

  // p1 is forced through once it has waited out STARVE_LIMIT consecutive p0 grants
  assign w_starved  = p1_valid && (r_starve_cnt == CW'(STARVE_LIMIT));
  assign w_grant_p0 = (r_state == S_IDLE) && p0_valid && !fence && !w_starved;
  assign w_grant_p1 = (r_state == S_IDLE) && !w_grant_p0 && p1_valid;
  assign w_grant    = w_grant_p0 || w_grant_p1;

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: grant in IDLE, address then data handshake downstream
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_grant) w_state_nxt = S_REQ;
      S_REQ: begin
        if (dbus_addr_ok) w_state_nxt = dbus_data_ok ? S_IDLE : S_WAIT;
      end
      S_WAIT: if (dbus_data_ok) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs: request valid only in REQ; completion routed to the latched port
  always_comb begin
    dbus_valid = (r_state == S_REQ);
    busy       = (r_state != S_IDLE);
    // Gated by reset so a transaction abandoned by reset never signals completion
    w_done     = reset &&
                 (((r_state == S_REQ) && dbus_addr_ok && dbus_data_ok) ||
                  ((r_state == S_WAIT) && dbus_data_ok));
    p0_ok      = w_done && !r_sel_p1;
    p1_ok      = w_done && r_sel_p1;
    rdata      = dbus_rdata;
  end

  // Starvation counter: counts p0 wins over a waiting p1, cleared when p1 wins
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_starve_cnt <= '0;
    end else if (w_grant_p1) begin
      r_starve_cnt <= '0;
    end else if (w_grant_p0 && p1_valid && (r_starve_cnt != CW'(STARVE_LIMIT))) begin
      r_starve_cnt <= r_starve_cnt + CW'(1);
    end
  end

  // Request capture on grant; fields are held until the next grant
  always_ff @(posedge clk) begin
    if (w_grant) begin
      r_sel_p1 <= w_grant_p1;
      r_addr   <= w_grant_p1 ? p1_addr   : p0_addr;
      r_size   <= w_grant_p1 ? p1_size   : p0_size;
      r_strobe <= w_grant_p1 ? p1_strobe : p0_strobe;
      r_data   <= w_grant_p1 ? p1_data   : p0_data;
    end
  end

  assign dbus_addr   = r_addr;
  assign dbus_size   = r_size;
  assign dbus_strobe = r_strobe;
  assign dbus_data   = r_data;

endmodule

// File: tb/tb_dbus_arbiter.sv
// Directed bench for dbus_arbiter: reset, single-cycle and split handshakes, starvation rotation, fence, reset mid-transaction.
// Inputs change 2ns after the rising edge; outputs are compared 1ns later, well before the next edge.
// Expected values are hand-computed constants in the step sequence.
module tb_dbus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        p0_valid, p1_valid;
  logic [31:0] p0_addr, p1_addr;
  logic [2:0]  p0_size, p1_size;
  logic [7:0]  p0_strobe, p1_strobe;
  logic [63:0] p0_data, p1_data;
  logic        p0_ok, p1_ok;
  logic [63:0] rdata;
  logic        dbus_valid;
  logic [31:0] dbus_addr;
  logic [2:0]  dbus_size;
  logic [7:0]  dbus_strobe;
  logic [63:0] dbus_data;
  logic        dbus_addr_ok, dbus_data_ok;
  logic [63:0] dbus_rdata;
  logic        fence;
  logic        busy;

  int total = 0;
  int fails = 0;

  always #5 clk = ~clk;

  dbus_arbiter #(.STARVE_LIMIT(4), .DATA_W(64)) dut (
    .clk(clk), .reset(reset),
    .p0_valid(p0_valid), .p0_addr(p0_addr), .p0_size(p0_size), .p0_strobe(p0_strobe), .p0_data(p0_data),
    .p1_valid(p1_valid), .p1_addr(p1_addr), .p1_size(p1_size), .p1_strobe(p1_strobe), .p1_data(p1_data),
    .p0_ok(p0_ok), .p1_ok(p1_ok), .rdata(rdata),
    .dbus_valid(dbus_valid), .dbus_addr(dbus_addr), .dbus_size(dbus_size),
    .dbus_strobe(dbus_strobe), .dbus_data(dbus_data),
    .dbus_addr_ok(dbus_addr_ok), .dbus_data_ok(dbus_data_ok), .dbus_rdata(dbus_rdata),
    .fence(fence), .busy(busy)
  );

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    p0_valid = 0; p0_addr = 32'h0; p0_size = 3'd0; p0_strobe = 8'h0; p0_data = 64'h0;
    p1_valid = 0; p1_addr = 32'h0; p1_size = 3'd0; p1_strobe = 8'h0; p1_data = 64'h0;
    dbus_addr_ok = 0; dbus_data_ok = 0; dbus_rdata = 64'h0; fence = 0;

    // Reset
    tick(); tick();
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_valid", 64'(dbus_valid), 64'd0);
    chk("rst_p0_ok", 64'(p0_ok), 64'd0);
    chk("rst_p1_ok", 64'(p1_ok), 64'd0);
    tick();
    reset = 1'b1;

    // Single p1 transaction, both oks at N+1
    tick();                                   // cycle N
    p1_valid = 1; p1_addr = 32'h8000_1000; p1_size = 3'd3; p1_strobe = 8'hFF; p1_data = 64'h1111_2222_3333_4444;
    #1;
    chk("n_busy", 64'(busy), 64'd0);
    tick();                                   // N+1
    dbus_addr_ok = 1; dbus_data_ok = 1; dbus_rdata = 64'h0123_4567_89AB_CDEF;
    #1;
    chk("n1_valid", 64'(dbus_valid), 64'd1);
    chk("n1_addr", 64'(dbus_addr), 64'h8000_1000);
    chk("n1_strobe", 64'(dbus_strobe), 64'hFF);
    chk("n1_data", dbus_data, 64'h1111_2222_3333_4444);
    chk("n1_p1_ok", 64'(p1_ok), 64'd1);
    chk("n1_p0_ok", 64'(p0_ok), 64'd0);
    chk("n1_rdata", rdata, 64'h0123_4567_89AB_CDEF);
    tick();                                   // N+2
    p1_valid = 0; dbus_addr_ok = 0; dbus_data_ok = 0;
    #1;
    chk("n2_busy", 64'(busy), 64'd0);
    chk("n2_p1_ok", 64'(p1_ok), 64'd0);

    // p0 with split handshake: addr_ok at N+1, data_ok at N+4
    tick();                                   // N
    p0_valid = 1; p0_addr = 32'h1234_5678; p0_size = 3'd2; p0_strobe = 8'h0F; p0_data = 64'hA5A5_0000_5A5A_FFFF;
    tick();                                   // N+1
    dbus_addr_ok = 1;
    #1;
    chk("s1_valid", 64'(dbus_valid), 64'd1);
    chk("s1_addr", 64'(dbus_addr), 64'h1234_5678);
    chk("s1_size", 64'(dbus_size), 64'd2);
    chk("s1_p0_ok", 64'(p0_ok), 64'd0);
    tick();                                   // N+2, stray addr_ok in WAIT
    #1;
    chk("s2_valid", 64'(dbus_valid), 64'd0);
    chk("s2_busy", 64'(busy), 64'd1);
    chk("s2_addr_hold", 64'(dbus_addr), 64'h1234_5678);
    tick();                                   // N+3
    dbus_addr_ok = 0;
    #1;
    chk("s3_valid", 64'(dbus_valid), 64'd0);
    chk("s3_p0_ok", 64'(p0_ok), 64'd0);
    tick();                                   // N+4
    dbus_data_ok = 1; dbus_rdata = 64'hDEAD_BEEF_CAFE_F00D;
    #1;
    chk("s4_p0_ok", 64'(p0_ok), 64'd1);
    chk("s4_p1_ok", 64'(p1_ok), 64'd0);
    chk("s4_rdata", rdata, 64'hDEAD_BEEF_CAFE_F00D);
    tick();                                   // N+5, responses in IDLE are ignored
    p0_valid = 0; dbus_addr_ok = 1; dbus_data_ok = 1;
    #1;
    chk("s5_busy", 64'(busy), 64'd0);
    chk("s5_p0_ok", 64'(p0_ok), 64'd0);
    chk("s5_p1_ok", 64'(p1_ok), 64'd0);
    tick();
    #1;
    chk("s6_busy", 64'(busy), 64'd0);

    // Starvation rotation: both valid, 1-cycle downstream, limit 4
    p0_valid = 1; p0_addr = 32'h0000_00A0;
    p1_valid = 1; p1_addr = 32'h0000_00B0;
    for (int i = 0; i < 10; i++) begin
      tick();                                 // REQ
      #1;
      if (i == 4 || i == 9) begin
        chk($sformatf("rot%0d_addr", i), 64'(dbus_addr), 64'h0B0);
        chk($sformatf("rot%0d_p1_ok", i), 64'(p1_ok), 64'd1);
      end else begin
        chk($sformatf("rot%0d_addr", i), 64'(dbus_addr), 64'h0A0);
        chk($sformatf("rot%0d_p0_ok", i), 64'(p0_ok), 64'd1);
      end
      tick();                                 // IDLE
      if (i == 9) begin
        p0_valid = 0; p1_valid = 0;
      end
    end
    tick();
    #1;
    chk("rot_end_busy", 64'(busy), 64'd0);

    // Fence: p1 wins while fenced, p0 only after fence drops
    fence = 1; p0_valid = 1; p1_valid = 1;
    tick();                                   // REQ
    #1;
    chk("fen_addr", 64'(dbus_addr), 64'h0B0);
    chk("fen_p1_ok", 64'(p1_ok), 64'd1);
    tick();                                   // IDLE, p1 done, p0 still fenced
    p1_valid = 0;
    tick();
    #1;
    chk("fen_blocked_busy", 64'(busy), 64'd0);
    fence = 0;
    tick();                                   // REQ for p0; fence rising mid-flight
    fence = 1;
    #1;
    chk("fen_p0_addr", 64'(dbus_addr), 64'h0A0);
    chk("fen_p0_ok", 64'(p0_ok), 64'd1);
    tick();
    p0_valid = 0; fence = 0;
    dbus_addr_ok = 0; dbus_data_ok = 0;

    // Reset in WAIT abandons the transaction
    tick();
    p1_valid = 1; p1_addr = 32'h0000_0C00;
    tick();                                   // REQ
    dbus_addr_ok = 1;
    tick();                                   // WAIT
    dbus_addr_ok = 0; p1_valid = 0;
    #1;
    chk("rw_busy", 64'(busy), 64'd1);
    reset = 1'b0;
    tick();                                   // IDLE after reset
    reset = 1'b1; dbus_data_ok = 1;
    #1;
    chk("rw_p1_ok", 64'(p1_ok), 64'd0);
    chk("rw_busy_idle", 64'(busy), 64'd0);
    tick();
    dbus_data_ok = 0;
    #1;
    chk("rw_busy_after", 64'(busy), 64'd0);
    p0_valid = 1; p0_addr = 32'h0000_0055;
    tick();                                   // REQ
    dbus_addr_ok = 1; dbus_data_ok = 1;
    #1;
    chk("rw_next_addr", 64'(dbus_addr), 64'h055);
    chk("rw_next_p0_ok", 64'(p0_ok), 64'd1);
    tick();
    p0_valid = 0; dbus_addr_ok = 0; dbus_data_ok = 0;
    tick();
    #1;
    chk("final_busy", 64'(busy), 64'd0);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule

// File: doc/dbus_arbiter.md
DBUS_ARBITER -- requirements
Module: dbus_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4, SHALL set how many consecutive port-0 grants are allowed while port 1 waits.
REQ-002 Parameter DATA_W, default 64, SHALL set the data width; strobe width is DATA_W/8.
REQ-003 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  in  1  SHALL be a synchronous, active-low reset (0 = reset).
REQ-005 p0_valid/p0_addr/p0_size/p0_strobe/p0_data  in  1/32/3/DATA_W/8/DATA_W  SHALL carry the uncached-access request (port 0, high priority).
REQ-006 p1_valid/p1_addr/p1_size/p1_strobe/p1_data  in  1/32/3/DATA_W/8/DATA_W  SHALL carry the write-buffer drain request (port 1, low priority).
REQ-007 p0_ok/p1_ok  out  1  SHALL be the per-port one-cycle completion pulse; rdata  out  DATA_W  SHALL be valid whenever either ok is high.
REQ-008 dbus_valid/dbus_addr/dbus_size/dbus_strobe/dbus_data  out  1/32/3/DATA_W/8/DATA_W  SHALL form the single downstream request.
REQ-009 dbus_addr_ok/dbus_data_ok/dbus_rdata  in  1/1/DATA_W  SHALL form the downstream response.
REQ-010 fence  in  1  SHALL, while high, block new port-0 grants.
REQ-011 busy  out  1  SHALL be high whenever the FSM is not IDLE.

Function
REQ-012 FSM states: IDLE, REQ, WAIT; at most one outstanding transaction.
REQ-013 IDLE: grant is evaluated every cycle; on grant, the winning port's fields are latched and the FSM enters REQ next cycle.
REQ-014 Arbitration: p0 wins if p0_valid & ~fence & ~(p1_valid & starve_cnt==STARVE_LIMIT); otherwise p1 wins if p1_valid; otherwise no grant.
REQ-015 starve_cnt (width clog2(STARVE_LIMIT+1)): on a p0 grant with p1_valid high, +1 saturating at STARVE_LIMIT; on a p0 grant with p1_valid low, unchanged; on a p1 grant, cleared to 0.
REQ-016 REQ: dbus_valid=1, driven from latched fields held stable. On addr_ok&data_ok go to IDLE; on addr_ok only go to WAIT; otherwise stay in REQ.
REQ-017 WAIT: dbus_valid=0; on data_ok go to IDLE; otherwise stay in WAIT.
REQ-018 Completion: in the cycle data_ok is accepted (REQ with addr_ok, or WAIT), the latched port's ok=1 combinationally and rdata=dbus_rdata; the other ok=0.
REQ-019 Minimum latency: valid at cycle N gives dbus_valid at N+1; ok can be asserted no earlier than N+1 (addr_ok and data_ok both at N+1).
REQ-020 Back-to-back: no grant in the completion cycle; the next grant is evaluated in the following IDLE cycle (minimum 2-cycle issue spacing).
REQ-021 A requester drops valid only after its ok; if it drops valid earlier, the latched transaction still completes and ok still pulses.
REQ-022 dbus_addr_ok or dbus_data_ok received in IDLE is ignored; dbus_addr_ok in WAIT is ignored.
REQ-023 Changing fence affects only IDLE grant decisions; an in-flight port-0 transaction completes normally.
REQ-024 Outside REQ, dbus_addr/size/strobe/data hold the last latched values.

Reset
REQ-025 While reset=0 at a clock edge, on the next cycle: state=IDLE, starve_cnt=0, dbus_valid=0, p0_ok=0, p1_ok=0, busy=0.
REQ-026 A reset asserted mid-transaction abandons it with no ok pulse; downstream responses for it are ignored (per REQ-022).
REQ-027 Latched request fields need no reset value.

Verification
REQ-028 p1_valid only, addr=0x80001000, strobe=0xFF; addr_ok+data_ok at N+1 -> dbus_valid at N+1, p1_ok at N+1, busy back to 0 at N+2.
REQ-029 p0 and p1 both valid continuously, STARVE_LIMIT=4, 1-cycle downstream -> grants p0,p0,p0,p0,p1,p0... repeating.
REQ-030 fence=1 with p0 and p1 both valid -> p1 granted; p0 granted only once fence=0.
REQ-031 addr_ok at N+1, data_ok at N+4 with rdata=0xDEADBEEF_CAFEF00D -> dbus_valid high only at N+1; p0_ok and rdata correct at N+4 only.
REQ-032 reset=0 in WAIT, then data_ok after reset released -> no ok pulse; state IDLE; next request proceeds normally.
